// File: rtl/fnd_scan_decoder.sv
// Loopback monitor for the 4-digit FND scan driver: recovers the displayed 0..9999 value from fndCom/fndFont.
// Optional macro FND_DP_CAPTURE_EN captures decimal points into dp_out and frame equality.
`timescale 1ns/1ps

module fnd_scan_decoder #(
    parameter int SETTLE_CYC   = 4,
    parameter int FRAMES_MATCH = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  fndCom,
    input  logic [7:0]  fndFont,
    output logic [13:0] number,
    output logic        number_valid,
    output logic        digit_err,
    output logic [3:0]  dp_out
);
    localparam int SW = $clog2(SETTLE_CYC + 1);
    localparam int MW = $clog2(FRAMES_MATCH + 1);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYC);
    localparam logic [MW-1:0] MATCH_LAST  = MW'(FRAMES_MATCH);

    typedef enum logic [1:0] {S_WAIT, S_SETTLE, S_HELD} scan_state_t;

    scan_state_t       state, state_nxt;
    logic [3:0]        com_s1, com_s2, com_last, com_n;
    logic [7:0]        font_s1, font_s2;
    logic [SW-1:0]     settle_cnt, settle_nxt, run;
    logic              one_cold, fresh, capture;
    logic [1:0]        sel;
    logic              glyph_ok;
    logic [3:0]        glyph_val;
    logic [3:0][3:0]   digits;
    logic [3:0]        mask;
    logic [MW-1:0]     match_cnt;
    logic [13:0]       frame_sum, frame_val, prev_val;
    logic [3:0]        cur_dp, frame_dp, prev_dp;
    logic              frame_done, published;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            com_s1     <= '0;
            com_s2     <= '0;
            com_last   <= '0;
            font_s1    <= '0;
            font_s2    <= '0;
            state      <= S_WAIT;
            settle_cnt <= '0;
        end else begin
            com_s1     <= fndCom;
            com_s2     <= com_s1;
            com_last   <= com_s2;
            font_s1    <= fndFont;
            font_s2    <= font_s1;
            state      <= state_nxt;
            settle_cnt <= settle_nxt;
        end
    end

    assign com_n    = ~com_s2;
    assign one_cold = (com_n != 4'd0) && ((com_n & (com_n - 4'd1)) == 4'd0);
    assign fresh    = (state == S_WAIT) || (com_s2 != com_last);

    always_comb begin
        case (com_n)
            4'b0010: sel = 2'd1;
            4'b0100: sel = 2'd2;
            4'b1000: sel = 2'd3;
            default: sel = 2'd0;
        endcase
    end

    // A changed one-cold select restarts the dwell count; HELD suppresses repeat captures.
    always_comb begin
        state_nxt  = state;
        settle_nxt = settle_cnt;
        capture    = 1'b0;
        run        = fresh ? SW'(1) : settle_cnt + SW'(1);
        if (!one_cold) begin
            state_nxt = S_WAIT;
        end else if (fresh || state == S_SETTLE) begin
            if (run == SETTLE_LAST) begin
                capture   = 1'b1;
                state_nxt = S_HELD;
            end else begin
                state_nxt  = S_SETTLE;
                settle_nxt = run;
            end
        end
    end

    always_comb begin
        glyph_ok  = 1'b1;
        glyph_val = 4'd0;
        case (font_s2[6:0])
            7'h40: glyph_val = 4'd0;
            7'h79: glyph_val = 4'd1;
            7'h24: glyph_val = 4'd2;
            7'h30: glyph_val = 4'd3;
            7'h19: glyph_val = 4'd4;
            7'h12: glyph_val = 4'd5;
            7'h02: glyph_val = 4'd6;
            7'h78: glyph_val = 4'd7;
            7'h00: glyph_val = 4'd8;
            7'h10: glyph_val = 4'd9;
            7'h7F: glyph_val = 4'd0;
            default: glyph_ok = 1'b0;
        endcase
    end

    assign frame_sum = 14'(digits[3]) * 14'd1000 + 14'(digits[2]) * 14'd100
                     + 14'(digits[1]) * 14'd10 + 14'(digits[0]);

`ifdef FND_DP_CAPTURE_EN
    logic [3:0] dp_cap;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dp_cap <= '0;
        end else if (capture && glyph_ok) begin
            dp_cap[sel] <= ~font_s2[7];
        end
    end
    assign cur_dp = dp_cap;
`else
    logic unused_dp;
    assign unused_dp = font_s2[7];
    assign cur_dp    = 4'b0;
`endif

    // Frame evaluation runs before capture so a capture in the same cycle still wins on mask/match.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            digits       <= '0;
            mask         <= '0;
            digit_err    <= 1'b0;
            match_cnt    <= '0;
            prev_val     <= '0;
            prev_dp      <= '0;
            frame_val    <= '0;
            frame_dp     <= '0;
            frame_done   <= 1'b0;
            published    <= 1'b0;
            number       <= '0;
            number_valid <= 1'b0;
            dp_out       <= '0;
        end else begin
            number_valid <= 1'b0;
            frame_done   <= 1'b0;
            if (mask == 4'hF) begin
                mask       <= '0;
                frame_done <= 1'b1;
                frame_val  <= frame_sum;
                frame_dp   <= cur_dp;
                if (frame_sum == prev_val && cur_dp == prev_dp) begin
                    if (match_cnt != MATCH_LAST) begin
                        match_cnt <= match_cnt + MW'(1);
                    end
                end else begin
                    match_cnt <= MW'(1);
                    prev_val  <= frame_sum;
                    prev_dp   <= cur_dp;
                end
            end
            if (capture) begin
                if (glyph_ok) begin
                    digits[sel] <= glyph_val;
                    mask[sel]   <= 1'b1;
                end else begin
                    digit_err <= 1'b1;
                    mask      <= '0;
                    match_cnt <= '0;
                end
            end
            if (frame_done && match_cnt == MATCH_LAST &&
                (frame_val != number || frame_dp != dp_out || !published)) begin
                number       <= frame_val;
                dp_out       <= frame_dp;
                number_valid <= 1'b1;
                published    <= 1'b1;
            end
        end
    end
endmodule
